// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_unit_skid.sv
// Single-entry {pc, insn} skid buffer that catches a response arriving
// while the downstream output register is stalled.
module fetch_skid_buffer
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  fetch_pkt_t load_pkt,
    input  logic       unload,
    input  logic       clear,
    output logic       full,
    output fetch_pkt_t pkt
);

    // Occupancy: reset/clear dominate, then load, then unload.
    always_ff @(posedge clk) begin
        if (reset || clear)
            full <= 1'b0;
        else if (load)
            full <= 1'b1;
        else if (unload)
            full <= 1'b0;
    end

    // Payload is only meaningful while full, so it is captured on load only.
    always_ff @(posedge clk) begin
        if (reset)
            pkt <= '0;
        else if (load)
            pkt <= load_pkt;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// buffers one response across a downstream stall and squashes wrong-path
// fetches on redirect.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] ins_out,
    output logic        ins_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         skid_full;
    fetch_pkt_t   skid_pkt;
    fetch_pkt_t   resp_pkt;
    logic         out_free;
    logic         accept;
    logic         resp;
    logic         skid_load;
    logic         skid_unload;

    // No new request while a response is parked, so order is preserved.
    assign imem_req    = (state_q == S_REQ) && !skid_full;
    assign imem_addr   = pc_q;
    assign out_free    = !ins_valid || !stall_in;
    assign accept      = imem_req && imem_ready;
    assign resp        = (state_q == S_WAIT) && imem_rvalid;
    assign resp_pkt    = '{pc: req_pc_q, insn: imem_rdata};
    assign skid_load   = resp && !out_free && !redirect_valid;
    assign skid_unload = out_free && skid_full && !redirect_valid;

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .load_pkt (resp_pkt),
        .unload   (skid_unload),
        .clear    (redirect_valid),
        .full     (skid_full),
        .pkt      (skid_pkt)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_REQ;
        else
            state_q <= state_d;
    end

    // Next state; a redirect with a request still in flight detours via
    // S_DRAIN so the stale response is swallowed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (accept) state_d = redirect_valid ? S_DRAIN : S_WAIT;
            S_WAIT:  if (imem_rvalid)         state_d = S_REQ;
                     else if (redirect_valid) state_d = S_DRAIN;
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // PC: redirect wins; otherwise advance on each accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            if (redirect_valid)
                pc_q <= redirect_pc;
            else if (accept)
                pc_q <= pc_q + 32'd4;
            if (accept)
                req_pc_q <= pc_q;
        end
    end

    // IF/ID-facing output register: flush on redirect, refill when free
    // (skid first, then a fresh response, else a bubble), hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_out    <= '0;
            ins_out   <= NOP_INSN;
            ins_valid <= 1'b0;
        end else if (redirect_valid) begin
            ins_out   <= NOP_INSN;
            ins_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                PC_out    <= skid_pkt.pc;
                ins_out   <= skid_pkt.insn;
                ins_valid <= 1'b1;
            end else if (resp) begin
                PC_out    <= req_pc_q;
                ins_out   <= imem_rdata;
                ins_valid <= 1'b1;
            end else begin
                ins_out   <= NOP_INSN;
                ins_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a random
// run checked against a program-order scoreboard.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_in, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_out, ins_out;
    logic        ins_valid;

    int checks = 0;
    int errors = 0;

    // imem model controls: mem_lat 0 = random 1..4 cycles
    int          mem_lat   = 1;
    int          ready_pct = 100;
    logic [31:0] acc_log[$];
    logic        busy;
    int          cnt;
    logic [31:0] pend_addr;

    if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSN(NOP)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC_out(PC_out), .ins_out(ins_out), .ins_valid(ins_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Instruction memory: decides at each negedge what the next posedge sees.
    initial begin
        busy = 1'b0; cnt = 0; pend_addr = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (reset) begin
                busy = 1'b0;
                imem_ready = 1'b0;
            end else begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy = 1'b0;
                        imem_rvalid = 1'b1;
                        imem_rdata = insn_of(pend_addr);
                    end
                end
                if (imem_req) begin
                    checks++;
                    if (busy) begin
                        errors++;
                        $display("FAIL one_outstanding got req while busy addr=%h", imem_addr);
                    end
                end
                imem_ready = ($urandom_range(99) < ready_pct);
                if (imem_req && imem_ready && !busy) begin
                    busy = 1'b1;
                    pend_addr = imem_addr;
                    cnt = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
                    acc_log.push_back(imem_addr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        reset = 1'b0;
        acc_log.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_lat = 1; ready_pct = 100;
        step(); step();
        checks++;
        if (ins_valid !== 1'b0 || ins_out !== NOP || PC_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b pc=%h ins=%h want v=0 pc=0 ins=%h", ins_valid, PC_out, ins_out, NOP);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr got %h want 0", imem_addr);
        end
        reset = 1'b0;
        acc_log.delete();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reset_req got %b want 1", imem_req);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (c % 2 == 0) begin
                e = 32'((c / 2 - 1) * 4);
                if (ins_valid !== 1'b1 || PC_out !== e || ins_out !== insn_of(e)) begin
                    errors++;
                    $display("FAIL zero_wait_out c=%0d got v=%b pc=%h ins=%h want pc=%h ins=%h", c, ins_valid, PC_out, ins_out, e, insn_of(e));
                end
            end else if (ins_valid !== 1'b0 || ins_out !== NOP) begin
                errors++;
                $display("FAIL zero_wait_bubble c=%0d got v=%b ins=%h want v=0 ins=%h", c, ins_valid, ins_out, NOP);
            end
        end
        checks++;
        if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
            errors++; $display("FAIL zero_wait_addrs got n=%0d want 0,4,8 in order", acc_log.size());
        end
    endtask

    task automatic test_stall_skid();
        int n;
        do_reset();
        step(); step();
        stall_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (ins_valid !== 1'b1 || PC_out !== 32'h0 || ins_out !== insn_of(32'h0)) begin
                errors++;
                $display("FAIL stall_hold c=%0d got v=%b pc=%h ins=%h want pc=0 ins=%h", c, ins_valid, PC_out, ins_out, insn_of(32'h0));
            end
            if (c >= 1) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++; $display("FAIL skid_no_req c=%0d got %b want 0", c, imem_req);
                end
            end
        end
        stall_in = 1'b0;
        step();
        checks++;
        if (ins_valid !== 1'b1 || PC_out !== 32'h4 || ins_out !== insn_of(32'h4)) begin
            errors++;
            $display("FAIL skid_unload got v=%b pc=%h ins=%h want pc=4 ins=%h", ins_valid, PC_out, ins_out, insn_of(32'h4));
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL skid_resume got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr);
        end
        n = 0;
        do begin step(); n++; end while (ins_valid !== 1'b1 && n < 10);
        checks++;
        if (ins_valid !== 1'b1 || PC_out !== 32'h8 || ins_out !== insn_of(32'h8)) begin
            errors++; $display("FAIL skid_next got v=%b pc=%h want pc=8", ins_valid, PC_out);
        end
    endtask

    task automatic test_redirect_wait();
        int   n;
        logic bad, found;
        do_reset();
        mem_lat = 3;
        n = 0;
        while (acc_log.size() < 3 && n < 60) begin step(); n++; end
        checks++;
        if (acc_log.size() < 3 || acc_log[2] !== 32'h8 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rdw_setup got n=%0d req=%b want accept of 8 pending", acc_log.size(), imem_req);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (ins_valid !== 1'b0 || ins_out !== NOP || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rdw_flush got v=%b ins=%h req=%b addr=%h want v=0 ins=%h req=0 addr=100", ins_valid, ins_out, imem_req, imem_addr, NOP);
        end
        bad = 1'b0; found = 1'b0;
        for (int c = 0; c < 25 && !found; c++) begin
            step();
            if (ins_valid === 1'b1 && PC_out === 32'h8) bad = 1'b1;
            if (ins_valid === 1'b1 && PC_out === 32'h100) found = 1'b1;
        end
        checks++;
        if (bad || !found || ins_out !== insn_of(32'h100)) begin
            errors++; $display("FAIL rdw_target got wrongpath=%b found=%b ins=%h want 0,1,%h", bad, found, ins_out, insn_of(32'h100));
        end
        checks++;
        if (acc_log.size() < 4 || acc_log[3] !== 32'h100) begin
            errors++; $display("FAIL rdw_next_addr got n=%0d want 4th fetch at 100", acc_log.size());
        end
        mem_lat = 1;
    endtask

    task automatic test_redirect_accept();
        int   n;
        logic bad, found;
        do_reset();
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h10) && n < 60) begin step(); n++; end
        checks++;
        if (n >= 60) begin
            errors++; $display("FAIL rda_timeout got addr=%h want req at 10", imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0 || acc_log.size() == 0 || acc_log[acc_log.size()-1] !== 32'h10) begin
            errors++; $display("FAIL rda_drain got req=%b v=%b want req=0 v=0 with 10 accepted", imem_req, ins_valid);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL rda_refetch got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr);
        end
        bad = 1'b0; found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (ins_valid === 1'b1 && PC_out === 32'h10) bad = 1'b1;
            if (ins_valid === 1'b1 && PC_out === 32'h200) found = 1'b1;
        end
        checks++;
        if (bad || !found || ins_out !== insn_of(32'h200)) begin
            errors++; $display("FAIL rda_target got wrongpath=%b found=%b ins=%h want 0,1,%h", bad, found, ins_out, insn_of(32'h200));
        end
    endtask

    task automatic test_redirect_stalled();
        do_reset();
        step(); step();
        stall_in = 1'b1;
        step(); step();
        checks++;
        if (imem_req !== 1'b0 || PC_out !== 32'h0 || ins_valid !== 1'b1) begin
            errors++; $display("FAIL rds_setup got req=%b pc=%h v=%b want 0,0,1", imem_req, PC_out, ins_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (ins_valid !== 1'b0 || ins_out !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL rds_flush got v=%b ins=%h req=%b addr=%h want v=0 ins=%h req=1 addr=300", ins_valid, ins_out, imem_req, imem_addr, NOP);
        end
        step(); step();
        checks++;
        if (ins_valid !== 1'b1 || PC_out !== 32'h300 || ins_out !== insn_of(32'h300)) begin
            errors++; $display("FAIL rds_target got v=%b pc=%h ins=%h want pc=300", ins_valid, PC_out, ins_out);
        end
        step();
        checks++;
        if (ins_valid !== 1'b1 || PC_out !== 32'h300) begin
            errors++; $display("FAIL rds_hold got v=%b pc=%h want v=1 pc=300", ins_valid, PC_out);
        end
        stall_in = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || ins_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_setup got req=%b addr=%h v=%b want 1,fffffffc,0", imem_req, imem_addr, ins_valid);
        end
        step();
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got %h want 00000000", imem_addr);
        end
        stall_in = 1'b1;
        step();
        checks++;
        if (ins_valid !== 1'b1 || PC_out !== 32'hFFFF_FFFC || ins_out !== insn_of(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_out got v=%b pc=%h ins=%h want pc=fffffffc", ins_valid, PC_out, ins_out);
        end
        step();
        checks++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b0 || ins_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_wait got addr=%h req=%b v=%b want 4,0,1", imem_addr, imem_req, ins_valid);
        end
        reset = 1'b1;
        step();
        checks++;
        if (ins_valid !== 1'b0 || ins_out !== NOP || PC_out !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset got v=%b ins=%h pc=%h addr=%h want v=0 ins=%h pc=0 addr=0", ins_valid, ins_out, PC_out, imem_addr, NOP);
        end
        reset = 1'b0; stall_in = 1'b0;
        acc_log.delete();
    endtask

    // Random traffic; the model is just the architectural instruction
    // stream: each captured instruction is the next sequential PC, and a
    // redirect restarts the stream at its target.
    task automatic test_random();
        logic [31:0] exp_pc, hold_pc, hold_ins;
        logic        hold;
        int          consumed, idle;
        do_reset();
        mem_lat = 0; ready_pct = 70;
        exp_pc = 32'h0; hold = 1'b0; hold_pc = '0; hold_ins = '0;
        consumed = 0; idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall_in       = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8
                             : 32'h1000 + 32'($urandom_range(1023)) * 32'd4;
            if (!ins_valid) begin
                checks++;
                if (ins_out !== NOP) begin
                    errors++; $display("FAIL rnd_bubble cyc=%0d got ins=%h want %h", cyc, ins_out, NOP);
                end
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc; hold = 1'b0; idle = 0;
            end else if (ins_valid && !stall_in) begin
                checks++;
                if (PC_out !== exp_pc || ins_out !== insn_of(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_order cyc=%0d got pc=%h ins=%h want pc=%h ins=%h", cyc, PC_out, ins_out, exp_pc, insn_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; consumed++; hold = 1'b0; idle = 0;
            end else begin
                hold = ins_valid; hold_pc = PC_out; hold_ins = ins_out; idle++;
            end
            step();
            if (hold) begin
                checks++;
                if (ins_valid !== 1'b1 || PC_out !== hold_pc || ins_out !== hold_ins) begin
                    errors++;
                    $display("FAIL rnd_hold cyc=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", cyc, ins_valid, PC_out, ins_out, hold_pc, hold_ins);
                end
            end
            if (idle > 200) begin
                checks++; errors++;
                $display("FAIL rnd_progress_timeout cyc=%0d got no progress for %0d cycles want <=200", cyc, idle);
                break;
            end
        end
        stall_in = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (consumed < 100) begin
            errors++; $display("FAIL rnd_throughput got %0d consumed want >=100", consumed);
        end
        mem_lat = 1; ready_pct = 100;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_accept();
        test_redirect_stalled();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
